// File: rtl/canv_draw_agu.sv
// Pixel-to-VRAM address generator: clips pixels, packs them into words, merges
// writes that hit the same word and issues masked writes under backpressure.
module canv_draw_agu #(
   parameter int CORDW  = 16,
   parameter int WORD   = 32,
   parameter int ADDRW  = 20,
   parameter int SHIFTW = 3
) (
   input  logic                     clk_sys,
   input  logic                     rst_sys_n,
   input  logic [ADDRW-1:0]         addr_base,
   input  logic [SHIFTW-1:0]        addr_shift,
   input  logic [CORDW-1:0]         canv_w,
   input  logic [CORDW-1:0]         canv_h,
   input  logic                     pix_valid,
   output logic                     pix_ready,
   input  logic signed [CORDW-1:0]  px,
   input  logic signed [CORDW-1:0]  py,
   input  logic [WORD-1:0]          colour,
   input  logic                     flush,
   output logic                     wr_valid,
   input  logic                     wr_ready,
   output logic [ADDRW-1:0]         wr_addr,
   output logic [WORD-1:0]          wr_data,
   output logic [WORD-1:0]          wr_mask,
   output logic                     clip,
   output logic                     busy
);

   localparam int LINW = ADDRW + SHIFTW;
   localparam int BPW  = $clog2(WORD) + 1;

   // Later pixel wins on the bits it covers.
   function automatic logic [WORD-1:0] merge_bits(input logic [WORD-1:0] old_bits,
                                                  input logic [WORD-1:0] new_bits,
                                                  input logic [WORD-1:0] new_mask);
      return (old_bits & ~new_mask) | (new_bits & new_mask);
   endfunction

   logic              vld_p1, vld_p2, buf_vld, flush_pend;
   logic              rdy_p1, rdy_p2, fire, take_p2;
   logic              clip_p0;
   logic [LINW-1:0]   lin_p0, lin_p1;
   logic [WORD-1:0]   colour_p1;
   logic [BPW-1:0]    bpp_p1, pix_id_p1, pos_p1;
   logic [WORD-1:0]   pmask_p1, mask_p1, data_p1;
   logic [ADDRW-1:0]  addr_p1;
   logic [ADDRW-1:0]  addr_p2;
   logic [WORD-1:0]   data_p2, mask_p2;
   logic [ADDRW-1:0]  buf_addr, buf_addr_n;
   logic [WORD-1:0]   buf_data, buf_data_n, buf_mask, buf_mask_n;
   logic              buf_vld_n, buf_load, buf_full, same_addr;
   logic [WORD-1:0]   mrg_data, mrg_mask;
   logic              emit_req, emit_fire, slot, pend_clr;
   logic [ADDRW-1:0]  emit_addr;
   logic [WORD-1:0]   emit_data, emit_mask;

   // ---- stage 0: clip test and linear pixel index
   assign clip_p0 = px[CORDW-1] | py[CORDW-1] |
                    ($unsigned(px) >= canv_w) | ($unsigned(py) >= canv_h);
   assign lin_p0  = LINW'($unsigned(py)) * LINW'(canv_w) + LINW'($unsigned(px));
   assign fire    = pix_valid && pix_ready;

   // ---- stage 1: word address, pixel slot and lane masks
   assign bpp_p1    = BPW'(WORD >> addr_shift);
   assign pix_id_p1 = lin_p1[BPW-1:0] & ~({BPW{1'b1}} << addr_shift);
   assign pos_p1    = pix_id_p1 * bpp_p1;
   assign pmask_p1  = {WORD{1'b1}} >> (BPW'(WORD) - bpp_p1);
   assign mask_p1   = pmask_p1 << pos_p1;
   assign data_p1   = (colour_p1 & pmask_p1) << pos_p1;
   assign addr_p1   = addr_base + ADDRW'(lin_p1 >> addr_shift);

   // ---- stage 2: combine buffer and write emission
   assign slot      = !wr_valid || wr_ready;
   assign buf_full  = buf_vld && (&buf_mask);
   assign same_addr = buf_vld && !buf_full && (buf_addr == addr_p2);
   assign mrg_mask  = (same_addr ? buf_mask : '0) | mask_p2;
   assign mrg_data  = merge_bits(same_addr ? buf_data : '0, data_p2, mask_p2);

   always_comb begin
      buf_vld_n  = buf_vld;
      buf_load   = 1'b0;
      buf_addr_n = addr_p2;
      buf_data_n = mrg_data;
      buf_mask_n = mrg_mask;
      emit_req   = 1'b0;
      emit_addr  = buf_addr;
      emit_data  = buf_data;
      emit_mask  = buf_mask;
      pend_clr   = 1'b0;
      if (vld_p2) begin
         if (buf_vld && !same_addr) begin
            emit_req = 1'b0 | 1'b1;
            if (slot) begin
               buf_load   = 1'b1;
               buf_data_n = data_p2;
               buf_mask_n = mask_p2;
            end
         end else if (&mrg_mask) begin
            // A merge that completes the word goes straight out.
            emit_req  = 1'b1;
            emit_addr = addr_p2;
            emit_data = mrg_data;
            emit_mask = mrg_mask;
            if (slot) buf_vld_n = 1'b0;
         end else begin
            buf_load = 1'b1;
         end
      end else if (buf_full) begin
         emit_req = 1'b1;
         if (slot) buf_vld_n = 1'b0;
      end else if (flush_pend && !vld_p1) begin
         if (buf_vld) begin
            emit_req = 1'b1;
            if (slot) begin
               buf_vld_n = 1'b0;
               pend_clr  = 1'b1;
            end
         end else begin
            pend_clr = 1'b1;
         end
      end
      if (buf_load) buf_vld_n = 1'b1;
   end

   assign emit_fire = emit_req && slot;
   assign take_p2   = vld_p2 && (!emit_req || slot);
   assign rdy_p2    = !vld_p2 || take_p2;
   assign rdy_p1    = !vld_p1 || rdy_p2;
   assign pix_ready = rst_sys_n && rdy_p1;
   assign busy      = vld_p1 | vld_p2 | buf_vld | flush_pend | wr_valid;

   always_ff @(posedge clk_sys or negedge rst_sys_n) begin
      if (!rst_sys_n) begin
         vld_p1     <= 1'b0;
         vld_p2     <= 1'b0;
         buf_vld    <= 1'b0;
         flush_pend <= 1'b0;
         clip       <= 1'b0;
         wr_valid   <= 1'b0;
         wr_addr    <= '0;
         wr_data    <= '0;
         wr_mask    <= '0;
      end else begin
         clip       <= fire && clip_p0;
         flush_pend <= flush || (flush_pend && !pend_clr);
         buf_vld    <= buf_vld_n;
         if (rdy_p1) vld_p1 <= fire && !clip_p0;
         if (rdy_p2) vld_p2 <= vld_p1;
         if (emit_fire) begin
            wr_valid <= 1'b1;
            wr_addr  <= emit_addr;
            wr_data  <= emit_data;
            wr_mask  <= emit_mask;
         end else if (wr_ready) begin
            wr_valid <= 1'b0;
         end
      end
   end

   always_ff @(posedge clk_sys) begin
      if (fire) begin
         lin_p1    <= lin_p0;
         colour_p1 <= colour;
      end
      if (vld_p1 && rdy_p2) begin
         addr_p2 <= addr_p1;
         data_p2 <= data_p1;
         mask_p2 <= mask_p1;
      end
      if (buf_load) begin
         buf_addr <= buf_addr_n;
         buf_data <= buf_data_n;
         buf_mask <= buf_mask_n;
      end
   end

endmodule

// File: tb/tb_canv_draw_agu.sv
// Bench for canv_draw_agu: directed scenarios with literal results plus
// randomized traffic scored against a word-combining model.
module tb_canv_draw_agu;

   logic                clk_sys = 1'b0;
   logic                rst_sys_n = 1'b1;
   logic [19:0]         addr_base = '0;
   logic [2:0]          addr_shift = '0;
   logic [15:0]         canv_w = 16'd320;
   logic [15:0]         canv_h = 16'd240;
   logic                pix_valid = 1'b0;
   logic                pix_ready;
   logic signed [15:0]  px = '0;
   logic signed [15:0]  py = '0;
   logic [31:0]         colour = '0;
   logic                flush = 1'b0;
   logic                wr_valid;
   logic                wr_ready = 1'b1;
   logic [19:0]         wr_addr;
   logic [31:0]         wr_data;
   logic [31:0]         wr_mask;
   logic                clip;
   logic                busy;

   canv_draw_agu dut (
      .clk_sys(clk_sys), .rst_sys_n(rst_sys_n), .addr_base(addr_base),
      .addr_shift(addr_shift), .canv_w(canv_w), .canv_h(canv_h),
      .pix_valid(pix_valid), .pix_ready(pix_ready), .px(px), .py(py),
      .colour(colour), .flush(flush), .wr_valid(wr_valid), .wr_ready(wr_ready),
      .wr_addr(wr_addr), .wr_data(wr_data), .wr_mask(wr_mask),
      .clip(clip), .busy(busy)
   );

   always #5 clk_sys = ~clk_sys;

   typedef struct packed {
      logic [19:0] a;
      logic [31:0] d;
      logic [31:0] m;
   } wr_t;

   wr_t          exp_q[$];
   wr_t          act_log[$];
   int           checks = 0;
   int           errors = 0;
   int           cyc = 0;
   int           clip_cnt = 0;
   int           stall_cnt = 0;
   int           first_acc = -1;
   int           first_wv = -1;
   bit           exp_clip = 0;
   bit           mb_vld = 0;
   logic [19:0]  mb_addr;
   logic [31:0]  mb_data, mb_mask;
   bit           prev_stall = 0;
   logic [19:0]  prev_addr;
   logic [31:0]  prev_data, prev_mask;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
      end
   endtask

   function automatic void model_push();
      wr_t e;
      e.a = mb_addr;
      e.d = mb_data;
      e.m = mb_mask;
      exp_q.push_back(e);
      mb_vld = 0;
   endfunction

   // Word-level view: a pixel lands in word base+lin/ppw at slot lin%ppw.
   function automatic void model_pix(input int x, input int y, input logic [31:0] c);
      int lin, s, n, pid;
      logic [31:0] pm, m, d;
      logic [19:0] a;
      if (x < 0 || y < 0 || x >= int'(canv_w) || y >= int'(canv_h)) begin
         exp_clip = 1;
         return;
      end
      s   = int'(addr_shift);
      lin = y * int'(canv_w) + x;
      n   = 32 >> s;
      pid = lin % (1 << s);
      pm  = (n == 32) ? 32'hFFFF_FFFF : ((32'h1 << n) - 32'h1);
      m   = pm << (pid * n);
      d   = (c & pm) << (pid * n);
      a   = 20'(int'(addr_base) + (lin / (1 << s)));
      if (mb_vld && mb_addr != a) model_push();
      if (!mb_vld) begin
         mb_vld  = 1;
         mb_addr = a;
         mb_data = d;
         mb_mask = m;
      end else begin
         mb_data = (mb_data & ~m) | d;
         mb_mask = mb_mask | m;
      end
      if (mb_mask == 32'hFFFF_FFFF) model_push();
   endfunction

   initial begin : monitor
      wr_t e, w;
      forever begin
         @(negedge clk_sys);
         cyc++;
         if (!rst_sys_n) begin
            exp_q.delete();
            mb_vld = 0;
            exp_clip = 0;
            prev_stall = 0;
            chk("rst_pix_ready", {31'b0, pix_ready}, 0);
            chk("rst_busy", {31'b0, busy}, 0);
            chk("rst_wr_valid", {31'b0, wr_valid}, 0);
            chk("rst_clip", {31'b0, clip}, 0);
         end else begin
            chk("clip", {31'b0, clip}, {31'b0, exp_clip});
            exp_clip = 0;
            if (clip) clip_cnt++;
            if (prev_stall) begin
               chk("hold_valid", {31'b0, wr_valid}, 1);
               chk("hold_addr", {12'b0, wr_addr}, {12'b0, prev_addr});
               chk("hold_data", wr_data, prev_data);
               chk("hold_mask", wr_mask, prev_mask);
            end
            if (wr_valid && first_wv < 0) first_wv = cyc;
            if (wr_valid && wr_ready) begin
               w.a = wr_addr;
               w.d = wr_data;
               w.m = wr_mask;
               act_log.push_back(w);
               if (exp_q.size() == 0) begin
                  errors++;
                  $display("FAIL unexpected_write: got addr 0x%0h, required none", wr_addr);
               end else begin
                  e = exp_q.pop_front();
                  chk("wr_addr", {12'b0, wr_addr}, {12'b0, e.a});
                  chk("wr_data", wr_data, e.d);
                  chk("wr_mask", wr_mask, e.m);
               end
            end
            prev_stall = wr_valid && !wr_ready;
            prev_addr  = wr_addr;
            prev_data  = wr_data;
            prev_mask  = wr_mask;
            if (pix_valid && !pix_ready) stall_cnt++;
            if (pix_valid && pix_ready) begin
               if (first_acc < 0) first_acc = cyc;
               model_pix(int'(px), int'(py), colour);
            end
            if (flush && mb_vld) model_push();
         end
      end
   end

   task automatic set_cfg(input int s, input int base, input int w, input int h);
      addr_shift = 3'(s);
      addr_base  = 20'(base);
      canv_w     = 16'(w);
      canv_h     = 16'(h);
   endtask

   task automatic send_pix(input int x, input int y, input logic [31:0] c);
      int n = 0;
      pix_valid = 1'b1;
      px = 16'(x);
      py = 16'(y);
      colour = c;
      @(negedge clk_sys);
      while (!pix_ready && n < 200) begin
         @(negedge clk_sys);
         n++;
      end
      if (!pix_ready) begin
         errors++;
         $display("FAIL accept_timeout: pix_ready 0 after %0d cycles, required 1", n);
      end
      @(posedge clk_sys);
      #1;
      pix_valid = 1'b0;
   endtask

   task automatic pulse_flush();
      flush = 1'b1;
      @(posedge clk_sys);
      #1;
      flush = 1'b0;
   endtask

   task automatic wait_idle(input int lim, input bit rnd);
      int n = 0;
      while (busy && n < lim) begin
         @(posedge clk_sys);
         #1;
         if (rnd) wr_ready = ($urandom_range(0, 3) != 0);
         n++;
      end
      checks++;
      if (busy) begin
         errors++;
         $display("FAIL idle_timeout: busy 1 after %0d cycles, required 0", n);
      end
   endtask

   task automatic chk_log(input string nm, input int i, input logic [19:0] a,
                          input logic [31:0] d, input logic [31:0] m);
      wr_t e;
      if (i < act_log.size()) begin
         e = act_log[i];
         chk({nm, "_addr"}, {12'b0, e.a}, {12'b0, a});
         chk({nm, "_data"}, e.d, d);
         chk({nm, "_mask"}, e.m, m);
      end else begin
         checks++;
         errors++;
         $display("FAIL %s_missing: got %0d writes, required more than %0d", nm, act_log.size(), i);
      end
   endtask

   initial begin : watchdog
      #600000;
      errors++;
      $display("FAIL watchdog: simulation time limit reached");
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $fatal(1, "watchdog");
   end

   initial begin : driver
      int w, h, x, y;
      #1 rst_sys_n = 1'b0;
      repeat (3) @(posedge clk_sys);
      #1 rst_sys_n = 1'b1;
      @(negedge clk_sys);
      chk("post_rst_pix_ready", {31'b0, pix_ready}, 1);
      chk("post_rst_busy", {31'b0, busy}, 0);

      // Single pixel then flush
      set_cfg(2, 'h1000, 320, 240);
      act_log.delete();
      send_pix(5, 2, 32'hAB);
      pulse_flush();
      wait_idle(50, 0);
      chk("t1_count", act_log.size(), 1);
      chk_log("t1", 0, 20'h10A1, 32'h0000_AB00, 32'h0000_FF00);

      // Four pixels fill one word with no flush
      act_log.delete();
      send_pix(0, 0, 32'h11);
      send_pix(1, 0, 32'h22);
      send_pix(2, 0, 32'h33);
      send_pix(3, 0, 32'h44);
      wait_idle(50, 0);
      chk("t2_count", act_log.size(), 1);
      chk_log("t2", 0, 20'h01000, 32'h4433_2211, 32'hFFFF_FFFF);

      // Clipped pixels
      act_log.delete();
      clip_cnt = 0;
      stall_cnt = 0;
      send_pix(-1, 0, 32'h1);
      send_pix(320, 0, 32'h2);
      send_pix(0, 240, 32'h3);
      repeat (3) @(posedge clk_sys);
      #1;
      chk("t3_clips", clip_cnt, 3);
      chk("t3_writes", act_log.size(), 0);
      chk("t3_stalls", stall_cnt, 0);
      chk("t3_busy", {31'b0, busy}, 0);

      // Streaming full words against a stalled write port
      set_cfg(0, 'h2000, 320, 240);
      act_log.delete();
      stall_cnt = 0;
      first_acc = -1;
      first_wv = -1;
      wr_ready = 1'b0;
      fork
         begin
            for (int i = 0; i < 8; i++) send_pix(i, 0, 32'hC0DE_0000 + 32'(i));
         end
         begin
            repeat (10) @(posedge clk_sys);
            #1 wr_ready = 1'b1;
         end
      join
      wait_idle(100, 0);
      chk("t4_latency", first_wv - first_acc, 3);
      chk("t4_pix_ready_drop", {31'b0, stall_cnt != 0}, 1);
      chk("t4_count", act_log.size(), 8);
      for (int i = 0; i < 8; i++)
         chk_log("t4", i, 20'h2000 + 20'(i), 32'hC0DE_0000 + 32'(i), 32'hFFFF_FFFF);

      // Address change evicts the buffer
      set_cfg(2, 'h1000, 320, 240);
      act_log.delete();
      send_pix(0, 0, 32'h05);
      send_pix(4, 0, 32'h06);
      pulse_flush();
      wait_idle(50, 0);
      chk("t5_count", act_log.size(), 2);
      chk_log("t5a", 0, 20'h01000, 32'h0000_0005, 32'h0000_00FF);
      chk_log("t5b", 1, 20'h01001, 32'h0000_0006, 32'h0000_00FF);

      // Reset with a pixel in stage 2 and a valid buffer
      act_log.delete();
      send_pix(0, 0, 32'h07);
      send_pix(1, 0, 32'h08);
      @(posedge clk_sys);
      #1;
      chk("t6_busy_before", {31'b0, busy}, 1);
      rst_sys_n = 1'b0;
      @(posedge clk_sys);
      @(posedge clk_sys);
      #1 rst_sys_n = 1'b1;
      repeat (6) @(posedge clk_sys);
      #1;
      chk("t6_writes", act_log.size(), 0);
      chk("t6_busy", {31'b0, busy}, 0);
      chk("t6_pix_ready", {31'b0, pix_ready}, 1);

      // Randomized traffic
      for (int k = 0; k < 6; k++) begin
         w = 6 + int'($urandom_range(0, 19));
         h = 3 + int'($urandom_range(0, 3));
         set_cfg(k % 4, int'($urandom_range(0, 20'hFFFFF)), w, h);
         for (int c = 0; c < 300; c++) begin
            x = int'($urandom_range(0, w + 3)) - 2;
            y = int'($urandom_range(0, h + 1)) - 1;
            pix_valid = ($urandom_range(0, 9) < 7);
            px = 16'(x);
            py = 16'(y);
            colour = $urandom;
            wr_ready = ($urandom_range(0, 9) < 7);
            flush = ($urandom_range(0, 24) == 0);
            @(posedge clk_sys);
            #1;
            if (flush) begin
               flush = 1'b0;
               pix_valid = 1'b0;
               wait_idle(300, 1);
            end
         end
         pix_valid = 1'b0;
         pulse_flush();
         wait_idle(400, 1);
         wr_ready = 1'b1;
         chk("rnd_drain", exp_q.size(), 0);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/canv_draw_agu.md
CANV_DRAW_AGU -- requirements
Module: canv_draw_agu

Interface
REQ-001 Parameters SHALL be:
- CORDW, 16, signed coordinate width (bits)
- WORD, 32, machine word / VRAM data width (bits)
- ADDRW, 20, VRAM word address width (bits)
- SHIFTW, 3, address shift width (bits)
REQ-002 Ports SHALL be:
- clk_sys  in  1  system clock
- rst_sys_n  in  1  reset; asynchronous, active-low
- addr_base  in  ADDRW  canvas base word address
- addr_shift  in  SHIFTW  log2 pixels per word; bpp = WORD>>addr_shift
- canv_w, canv_h  in  CORDW  canvas width/height in pixels (unsigned)
- pix_valid / pix_ready  in / out  1  pixel input handshake
- px, py  in  CORDW  signed pixel coordinates
- colour  in  WORD  pixel colour; low bpp bits used
- flush  in  1  single-cycle request to emit the combine buffer
- wr_valid / wr_ready  out / in  1  VRAM write handshake
- wr_addr  out  ADDRW  VRAM word address
- wr_data  out  WORD  write data
- wr_mask  out  WORD  bit-granular write enable
- clip  out  1  one-cycle pulse per discarded pixel
- busy  out  1  any pixel in flight, buffered or pending write
REQ-003 addr_base, addr_shift, canv_w and canv_h SHALL be held stable while busy=1; behaviour otherwise is undefined.

Function
REQ-010 Pixel transfer SHALL occur on a cycle with pix_valid && pix_ready.
REQ-011 Stage 1 SHALL register the pixel, the clip flag and lin = py*canv_w + px (at least ADDRW+SHIFTW bits, unsigned).
REQ-012 A pixel SHALL be clipped when px<0, py<0, px>=canv_w or py>=canv_h; it SHALL be consumed, pulse clip for one cycle in stage 1 and produce no write.
REQ-013 Stage 2 SHALL compute:
- word address: addr_base + (lin >> addr_shift), truncated to ADDRW
- pix_id: lin & ((1<<addr_shift)-1)
- mask: ((1<<bpp)-1) << (pix_id*bpp)
- data: (colour & ((1<<bpp)-1)) << (pix_id*bpp)
Pixel 0 SHALL occupy the least-significant bits.
REQ-014 A combine buffer SHALL hold {addr, data, mask, valid}. For each unclipped stage-2 pixel:
- buffer empty: load the pixel.
- same addr: mask |= new mask; bits under the new mask take new data (later pixel wins).
- different addr: move the buffer to the write output, then load the new pixel.
REQ-015 A buffer whose mask is all ones SHALL move to the write output on the next cycle, without waiting for a different address or flush.
REQ-016 flush SHALL set a pending flag. Once stages 1 and 2 hold no pixel, the buffer (if valid) SHALL move to the write output and the flag SHALL clear. If the buffer is empty, the flag SHALL clear with no write.
REQ-017 The write output SHALL be registered. wr_addr, wr_data and wr_mask SHALL be held stable while wr_valid && !wr_ready. A write SHALL complete on wr_valid && wr_ready.
REQ-018 Backpressure: when the buffer must emit and the output holds an uncompleted write, the pipeline SHALL stall. pix_ready SHALL be 0 when stage 1 cannot advance, and no pixel SHALL be lost or duplicated.
REQ-019 Throughput SHALL be one pixel per cycle when wr_ready=1.
REQ-020 Latency for addr_shift=0 SHALL be: pixel accepted in cycle N gives wr_valid=1 in cycle N+3.
REQ-021 busy SHALL be the OR of stage-1 valid, stage-2 valid, buffer valid, flush pending and wr_valid.

Reset
REQ-030 While rst_sys_n=0, all of the following SHALL be 0: stage valids, buffer valid, flush pending, wr_valid, clip and busy. pix_ready SHALL be 0 during reset and 1 from the first cycle after release.
REQ-031 Reset mid-operation SHALL discard all in-flight and buffered pixels with no write issued. wr_addr, wr_data and wr_mask SHALL reset to 0.

Verification
REQ-040 WORD=32, shift=2, base=0x1000, canv_w=320, canv_h=240. Pixel (5,2) colour 0xAB, then flush -> one write: addr 0x10A1, data 0x0000AB00, mask 0x0000FF00.
REQ-041 Same config. Pixels x=0..3, y=0, colours 0x11/0x22/0x33/0x44 on consecutive cycles, no flush -> one write: addr 0x1000, data 0x44332211, mask 0xFFFFFFFF.
REQ-042 Pixels (-1,0), (320,0), (0,240) -> three clip pulses, no write, pix_ready stays 1, busy returns to 0.
REQ-043 shift=0, 8 pixels streaming, wr_ready=0 for 10 cycles then 1:
- outputs stable while stalled
- pix_ready drops
- 8 writes in order, each mask 0xFFFFFFFF, first wr_valid at accept+3
REQ-044 Pixel (0,0) then (4,0) at shift=2, then flush -> write 0x1000 mask 0x000000FF, then write 0x1001 mask 0x000000FF.
REQ-045 rst_sys_n pulsed low with a pixel in stage 2 and a valid buffer -> no write after release, busy=0, pix_ready=1.
